// File: rtl/rtc_time_poller.sv
// Periodically burst-reads seconds/minutes/hours from a DS3231M through a byte-level
// I2C master, validates the BCD fields and publishes a coherent 24 h time snapshot.
module rtc_time_poller #(
  parameter int         CLK_FREQ       = 50000000,
  parameter int         POLL_MS        = 100,
  parameter logic [6:0] DEV_ADDR7      = 7'h68,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_poll_now,
  output logic       o_i2c_start,
  output logic       o_i2c_wr,
  output logic       o_i2c_rd,
  output logic       o_i2c_nack,
  output logic       o_i2c_stop,
  output logic [7:0] o_i2c_wr_byte,
  input  logic       i_i2c_done,
  input  logic       i_i2c_ack,
  input  logic       i_i2c_dataval,
  input  logic [7:0] i_i2c_rd_byte,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
  output logic       o_time_valid,
  output logic       o_err,
  output logic       o_busy
);

  localparam int POLL_CYCLES = CLK_FREQ / 1000 * POLL_MS;
  localparam int PW          = $clog2(POLL_CYCLES + 1);
  localparam int TW          = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] POLL_LAST    = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    ADDR_WR      = {DEV_ADDR7, 1'b0};
  localparam logic [7:0]    ADDR_RD      = {DEV_ADDR7, 1'b1};

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] ADDR_W  = 4'd1;
  localparam logic [3:0] REG_PTR = 4'd2;
  localparam logic [3:0] ADDR_R  = 4'd3;
  localparam logic [3:0] RD_SEC  = 4'd4;
  localparam logic [3:0] RD_MIN  = 4'd5;
  localparam logic [3:0] RD_HOUR = 4'd6;
  localparam logic [3:0] STOP_W  = 4'd7;
  localparam logic [3:0] CHECK   = 4'd8;
  localparam logic [3:0] FAIL    = 4'd9;

  logic [3:0]    state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    shadow_sec, shadow_min, shadow_hour;
  logic          poll_go, timeout;

  logic [7:0] sec_m, min_m, hour_m, hour_24;
  logic [3:0] pm_u;
  logic [1:0] pm_t;
  logic       hour_ok, time_ok;

  assign poll_go = i_enable && (i_poll_now || poll_cnt == POLL_LAST);
  assign timeout = (tmo_cnt == TIMEOUT_LAST);
  assign o_busy  = (state != IDLE);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    sec_m   = shadow_sec  & 8'h7F;
    min_m   = shadow_min  & 8'h7F;
    hour_m  = shadow_hour & 8'h7F;
    hour_ok = 1'b0;
    hour_24 = 8'h00;
    pm_u    = hour_m[3:0] + 4'd2;
    pm_t    = {1'b0, hour_m[4]} + 2'd1;
    if (pm_u > 4'd9) begin
      pm_u = pm_u - 4'd10;
      pm_t = pm_t + 2'd1;
    end
    if (hour_m[6]) begin
      // 12 h mode: 1..12 in bits 4:0, PM flag in bit 5; converted to 24 h in BCD.
      hour_ok = (hour_m[3:0] <= 4'd9) &&
                (hour_m[4] ? (hour_m[3:0] <= 4'd2) : (hour_m[3:0] != 4'd0));
      if (hour_m[4:0] == 5'h12) hour_24 = hour_m[5] ? 8'h12 : 8'h00;
      else if (hour_m[5])       hour_24 = {2'b00, pm_t, pm_u};
      else                      hour_24 = {3'b000, hour_m[4:0]};
    end else begin
      hour_ok = (hour_m <= 8'h23) && (hour_m[3:0] <= 4'd9);
      hour_24 = hour_m;
    end
    time_ok = (sec_m[6:4] <= 3'd5) && (sec_m[3:0] <= 4'd9) &&
              (min_m[6:4] <= 3'd5) && (min_m[3:0] <= 4'd9) && hour_ok;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      tmo_cnt       <= '0;
      shadow_sec    <= 8'h00;
      shadow_min    <= 8'h00;
      shadow_hour   <= 8'h00;
      o_i2c_start   <= 1'b0;
      o_i2c_wr      <= 1'b0;
      o_i2c_rd      <= 1'b0;
      o_i2c_nack    <= 1'b0;
      o_i2c_stop    <= 1'b0;
      o_i2c_wr_byte <= 8'h00;
      o_sec         <= 8'h00;
      o_min         <= 8'h00;
      o_hour        <= 8'h00;
      o_time_valid  <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here, so any branch that sets one yields exactly one cycle.
      o_i2c_start  <= 1'b0;
      o_i2c_wr     <= 1'b0;
      o_i2c_rd     <= 1'b0;
      o_i2c_nack   <= 1'b0;
      o_i2c_stop   <= 1'b0;
      o_time_valid <= 1'b0;
      if (state != IDLE && state != CHECK) tmo_cnt <= tmo_cnt + TW'(1);

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (poll_go) begin
            poll_cnt      <= '0;
            o_i2c_start   <= 1'b1;
            o_i2c_wr_byte <= ADDR_WR;
            state         <= ADDR_W;
          end else if (i_enable) begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        ADDR_W, REG_PTR, ADDR_R: begin
          if (i_i2c_done) begin
            tmo_cnt <= '0;
            if (!i_i2c_ack) begin
              o_i2c_stop <= 1'b1;
              o_err      <= 1'b1;
              state      <= FAIL;
            end else if (state == ADDR_W) begin
              o_i2c_wr      <= 1'b1;
              o_i2c_wr_byte <= 8'h00;
              state         <= REG_PTR;
            end else if (state == REG_PTR) begin
              o_i2c_start   <= 1'b1;
              o_i2c_wr_byte <= ADDR_RD;
              state         <= ADDR_R;
            end else begin
              o_i2c_rd <= 1'b1;
              state    <= RD_SEC;
            end
          end else if (timeout) begin
            tmo_cnt    <= '0;
            o_i2c_stop <= 1'b1;
            o_err      <= 1'b1;
            state      <= FAIL;
          end
        end
        RD_SEC, RD_MIN, RD_HOUR, STOP_W: begin
          if (i_i2c_dataval && state == RD_SEC)  shadow_sec  <= i_i2c_rd_byte;
          if (i_i2c_dataval && state == RD_MIN)  shadow_min  <= i_i2c_rd_byte;
          if (i_i2c_dataval && state == RD_HOUR) shadow_hour <= i_i2c_rd_byte;
          if (i_i2c_done) begin
            tmo_cnt <= '0;
            case (state)
              RD_SEC:  begin o_i2c_rd <= 1'b1; state <= RD_MIN; end
              RD_MIN:  begin o_i2c_rd <= 1'b1; o_i2c_nack <= 1'b1; state <= RD_HOUR; end
              RD_HOUR: begin o_i2c_stop <= 1'b1; state <= STOP_W; end
              default: begin
                // Snapshot is registered on entry to CHECK so all three fields move together.
                if (time_ok) begin
                  o_sec        <= sec_m;
                  o_min        <= min_m;
                  o_hour       <= hour_24;
                  o_time_valid <= 1'b1;
                  o_err        <= 1'b0;
                end else begin
                  o_err <= 1'b1;
                end
                state <= CHECK;
              end
            endcase
          end else if (timeout) begin
            tmo_cnt    <= '0;
            o_i2c_stop <= 1'b1;
            o_err      <= 1'b1;
            state      <= FAIL;
          end
        end
        CHECK: state <= IDLE;
        FAIL: begin
          if (i_i2c_done || timeout) begin
            tmo_cnt <= '0;
            o_err   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_time_poller.sv
// Scoreboarded bench for rtc_time_poller: a reactive I2C engine model answers commands,
// expected snapshots are queued per poll and compared when the DUT returns to IDLE.
module tb_rtc_time_poller;

  localparam int TMO = 100;
  localparam int LAT = 2;
  localparam logic [2:0] K_START = 3'd1, K_WR = 3'd2, K_RD = 3'd3, K_STOP = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic       nack;
    logic [7:0] data;
    int         cyc;
  } cmd_t;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       err;
    int         valids;
  } exp_t;

  logic       clk = 1'b0, i_rst = 1'b1, i_enable = 1'b0, i_poll_now = 1'b0;
  logic       o_i2c_start, o_i2c_wr, o_i2c_rd, o_i2c_nack, o_i2c_stop;
  logic [7:0] o_i2c_wr_byte;
  logic       i_i2c_done = 1'b0, i_i2c_ack = 1'b0, i_i2c_dataval = 1'b0;
  logic [7:0] i_i2c_rd_byte = 8'h00;
  logic [7:0] o_sec, o_min, o_hour;
  logic       o_time_valid, o_err, o_busy;

  int checks = 0, errors = 0;
  int cyc = 0, last_idle_cyc = 0, stop_done_cyc = -100, valid_cnt = 0;
  bit prev_busy = 0, last_was_stop = 0, nack_d0_f = 0, hang_f = 0;
  logic [7:0] model_sec = 8'h00, model_min = 8'h00, model_hour = 8'h00;
  cmd_t log_q[$];
  exp_t exp_q[$];
  logic [7:0] rd_q[$];
  int gap_q[$];

  rtc_time_poller #(
    .CLK_FREQ(20000), .POLL_MS(1), .DEV_ADDR7(7'h68), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_poll_now(i_poll_now),
    .o_i2c_start(o_i2c_start), .o_i2c_wr(o_i2c_wr), .o_i2c_rd(o_i2c_rd),
    .o_i2c_nack(o_i2c_nack), .o_i2c_stop(o_i2c_stop), .o_i2c_wr_byte(o_i2c_wr_byte),
    .i_i2c_done(i_i2c_done), .i_i2c_ack(i_i2c_ack), .i_i2c_dataval(i_i2c_dataval),
    .i_i2c_rd_byte(i_i2c_rd_byte),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_time_valid(o_time_valid), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Engine model: logs each command, answers after LAT cycles unless told to hang on reads.
  initial begin
    cmd_t e;
    int npulse;
    forever begin
      @(negedge clk);
      if (i_rst) continue;
      npulse = int'(o_i2c_start) + int'(o_i2c_wr) + int'(o_i2c_rd) + int'(o_i2c_stop);
      if (npulse != 0) begin
        checks++;
        if (npulse > 1) begin
          errors++;
          $display("FAIL cmd_one_hot: %0d command pulses in one cycle, required 1", npulse);
        end
        e.kind = o_i2c_start ? K_START : o_i2c_wr ? K_WR : o_i2c_rd ? K_RD : K_STOP;
        e.nack = o_i2c_nack;
        e.data = o_i2c_wr_byte;
        e.cyc  = cyc;
        log_q.push_back(e);
        if (e.kind == K_START && e.data == 8'hD0) gap_q.push_back(cyc - last_idle_cyc);
        last_was_stop = (e.kind == K_STOP);
        if (!(hang_f && e.kind == K_RD)) begin
          repeat (LAT) @(posedge clk);
          #1;
          i_i2c_done = 1'b1;
          i_i2c_ack  = !(nack_d0_f && e.kind == K_START && e.data == 8'hD0);
          if (e.kind == K_RD) begin
            i_i2c_dataval = 1'b1;
            i_i2c_rd_byte = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
          end
          @(posedge clk);
          #1;
          i_i2c_done = 1'b0; i_i2c_ack = 1'b0; i_i2c_dataval = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: each busy->idle edge closes one poll and is compared to the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (i_rst) begin
      prev_busy = 0;
      valid_cnt = 0;
    end else begin
      if (i_i2c_done && last_was_stop) stop_done_cyc = cyc;
      if (o_time_valid) begin
        valid_cnt++;
        checks++;
        if (cyc != stop_done_cyc + 1) begin
          errors++;
          $display("FAIL valid_latency: valid at cycle %0d, required %0d", cyc, stop_done_cyc + 1);
        end
      end
      if (o_busy && !prev_busy) valid_cnt = 0;
      if (!o_busy && prev_busy) begin
        last_idle_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_poll: poll ended with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          if ({o_sec, o_min, o_hour} !== {e.sec, e.min, e.hour} || o_err !== e.err ||
              valid_cnt != e.valids) begin
            errors++;
            $display("FAIL snapshot: got %h:%h:%h err=%b valids=%0d, required %h:%h:%h err=%b valids=%0d",
                     o_hour, o_min, o_sec, o_err, valid_cnt, e.hour, e.min, e.sec, e.err, e.valids);
          end
        end
      end
      prev_busy = o_busy;
    end
  end

  function automatic int bcd2i(input logic [7:0] b);
    if (b[3:0] > 4'd9 || b[7:4] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push_expect(input logic [7:0] s, m, h, input bit comm_fail);
    exp_t e;
    int sv, mv, hv, h24;
    bit ok;
    ok = !comm_fail;
    sv = bcd2i(s & 8'h7F);
    mv = bcd2i(m & 8'h7F);
    if (sv < 0 || sv > 59 || mv < 0 || mv > 59) ok = 0;
    if (h[6]) begin
      hv = bcd2i({3'b000, h[4:0]});
      if (hv < 1 || hv > 12) ok = 0;
      if (h[5]) h24 = (hv == 12) ? 12 : hv + 12;
      else      h24 = (hv == 12) ? 0 : hv;
    end else begin
      hv = bcd2i({2'b00, h[5:0]});
      if (hv < 0 || hv > 23) ok = 0;
      h24 = hv;
    end
    if (ok) begin
      model_sec  = s & 8'h7F;
      model_min  = m & 8'h7F;
      model_hour = i2bcd(h24);
    end
    e.sec = model_sec; e.min = model_min; e.hour = model_hour;
    e.err = !ok; e.valids = ok ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit seen, ok;
    seen = 0; ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (o_busy) seen = 1;
      else if (seen) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_complete: busy=%b seen=%b, required return to idle", name, o_busy, seen);
    end
    @(negedge clk);
  endtask

  task automatic do_poll(input logic [7:0] s, m, h, input bit nack_d0, input bit hang,
                         input string name);
    rd_q.delete();
    rd_q.push_back(s); rd_q.push_back(m); rd_q.push_back(h);
    log_q.delete();
    nack_d0_f = nack_d0;
    hang_f    = hang;
    push_expect(s, m, h, nack_d0 || hang);
    @(negedge clk); i_enable = 1'b1; i_poll_now = 1'b1;
    @(negedge clk); i_enable = 1'b0; i_poll_now = 1'b0;
    wait_idle(name);
    nack_d0_f = 0;
    hang_f    = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_sec, o_min, o_hour, o_time_valid, o_err, o_busy, o_i2c_start, o_i2c_wr,
         o_i2c_rd, o_i2c_nack, o_i2c_stop, o_i2c_wr_byte} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: %h:%h:%h err=%b busy=%b, required all zero", o_hour, o_min, o_sec, o_err, o_busy);
    end
    i_rst = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || log_q.size() != 0) begin
      errors++;
      $display("FAIL disabled_idle: busy=%b cmds=%0d, required 0 and 0", o_busy, log_q.size());
    end
  endtask

  task automatic test_basic;
    logic [2:0] ek[7] = '{K_START, K_WR, K_START, K_RD, K_RD, K_RD, K_STOP};
    logic [7:0] ed[7] = '{8'hD0, 8'h00, 8'hD1, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       en[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_poll(8'h45, 8'h59, 8'h23, 0, 0, "basic");
    checks++;
    if (log_q.size() != 7) begin
      errors++;
      $display("FAIL basic_cmd_count: %0d commands, required 7", log_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (log_q[i].kind !== ek[i] || (ek[i] <= K_WR && log_q[i].data !== ed[i]) ||
            (ek[i] == K_RD && log_q[i].nack !== en[i])) begin
          errors++;
          $display("FAIL basic_cmd%0d: kind=%0d byte=%h nack=%b, required kind=%0d byte=%h nack=%b",
                   i, log_q[i].kind, log_q[i].data, log_q[i].nack, ek[i], ed[i], en[i]);
        end
      end
    end
  endtask

  task automatic test_12h;
    do_poll(8'h01, 8'h02, 8'h72, 0, 0, "pm12");
    do_poll(8'h03, 8'h04, 8'h52, 0, 0, "am12");
    do_poll(8'h05, 8'h06, 8'h71, 0, 0, "pm11");
    do_poll(8'h07, 8'h08, 8'h49, 0, 0, "am9");
  endtask

  task automatic test_nack;
    do_poll(8'h10, 8'h11, 8'h12, 1, 0, "nack");
    checks++;
    if (log_q.size() != 2 || log_q[0].kind !== K_START || log_q[1].kind !== K_STOP) begin
      errors++;
      $display("FAIL nack_cmds: %0d commands, required start then stop", log_q.size());
    end
    do_poll(8'h01, 8'h02, 8'h03, 0, 0, "recover");
  endtask

  task automatic test_bad_bcd;
    do_poll(8'h5A, 8'h10, 8'h10, 0, 0, "bad_sec");
    do_poll(8'h10, 8'h60, 8'h10, 0, 0, "bad_min");
    do_poll(8'h10, 8'h10, 8'h24, 0, 0, "bad_hour");
  endtask

  task automatic test_timeout;
    int gap;
    do_poll(8'h20, 8'h21, 8'h22, 0, 1, "timeout");
    checks++;
    if (log_q.size() != 5 || log_q[3].kind !== K_RD || log_q[4].kind !== K_STOP) begin
      errors++;
      $display("FAIL timeout_cmds: %0d commands, required 5 ending rd, stop", log_q.size());
    end else begin
      gap = log_q[4].cyc - log_q[3].cyc;
      checks++;
      if (gap < TMO || gap > TMO + 2) begin
        errors++;
        $display("FAIL timeout_gap: stop %0d cycles after rd, required %0d..%0d", gap, TMO, TMO + 2);
      end
    end
  endtask

  task automatic test_periodic;
    int n;
    bit pulsed;
    logic [7:0] secs[3] = '{8'h11, 8'h12, 8'h13};
    rd_q.delete(); log_q.delete(); gap_q.delete();
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(secs[i]); rd_q.push_back(8'h22); rd_q.push_back(8'h13);
      push_expect(secs[i], 8'h22, 8'h13, 0);
    end
    @(negedge clk); i_enable = 1'b1;
    n = 0; pulsed = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1;
      i_poll_now = 1'b0;
      n = 0;
      foreach (log_q[i]) if (log_q[i].kind == K_START && log_q[i].data == 8'hD0) n++;
      if (n >= 1 && !pulsed && o_busy) begin
        i_poll_now = 1'b1;
        pulsed = 1;
      end
      if (n >= 3) break;
    end
    i_enable = 1'b0; i_poll_now = 1'b0;
    wait_idle("periodic");
    checks++;
    if (gap_q.size() != 3) begin
      errors++;
      $display("FAIL periodic_count: %0d polls, required 3", gap_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (gap_q[i] != 20) begin
          errors++;
          $display("FAIL periodic_gap%0d: %0d cycles idle to start, required 20", i, gap_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read;
    bit got;
    rd_q.delete(); log_q.delete();
    hang_f = 1;
    @(negedge clk); i_enable = 1'b1; i_poll_now = 1'b1;
    @(negedge clk); i_enable = 1'b0; i_poll_now = 1'b0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      foreach (log_q[i]) if (log_q[i].kind == K_RD) got = 1;
      if (got) break;
    end
    checks++;
    if (!got || o_busy !== 1'b1 || o_sec === 8'h00) begin
      errors++;
      $display("FAIL rst_setup: rd_seen=%b busy=%b sec=%h, required 1, 1, nonzero", got, o_busy, o_sec);
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_sec, o_min, o_hour, o_time_valid, o_err, o_busy, o_i2c_start, o_i2c_wr,
         o_i2c_rd, o_i2c_nack, o_i2c_stop, o_i2c_wr_byte} !== '0) begin
      errors++;
      $display("FAIL async_reset: %h:%h:%h err=%b busy=%b, required all zero", o_hour, o_min, o_sec, o_err, o_busy);
    end
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    hang_f = 0;
    model_sec = 8'h00; model_min = 8'h00; model_hour = 8'h00;
    repeat (5) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b, required 0", o_busy);
    end
    do_poll(8'h30, 8'h15, 8'h08, 0, 0, "after_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_12h();
    test_nack();
    test_bad_bcd();
    test_timeout();
    test_periodic();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
